// File: rtl/gate_checker_pkg.sv
// Shared types and constants for the 74xx quad 2-input gate truth-table checker.
package gate_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    localparam int NUM_VEC = 4;

    // Expected y per vector, indexed by {a,b}.
    localparam logic [NUM_VEC-1:0] TT_NAND = 4'b0111;
    localparam logic [NUM_VEC-1:0] TT_NOR  = 4'b0001;
    localparam logic [NUM_VEC-1:0] TT_AND  = 4'b1000;
    localparam logic [NUM_VEC-1:0] TT_OR   = 4'b1110;
    localparam logic [NUM_VEC-1:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_settle_timer.sv
// Clearable up-counter that flags expire once it reaches SETTLE_CYCLES-1.
module gate_settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [CW-1:0] cnt_q;

    assign expire = (cnt_q == CW'(SETTLE_CYCLES - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !expire) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/ic_gate_checker.sv
// Walks the four {a,b} vectors across LANES gate lanes and checks y against a truth table.
// Define GATE_CHECKER_ABORT_EN to stop the run at the first mismatching vector.
module ic_gate_checker
    import gate_checker_pkg::*;
#(
    parameter int LANES         = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [NUM_VEC-1:0] tt,
    output logic [LANES-1:0]   a,
    output logic [LANES-1:0]   b,
    input  logic [LANES-1:0]   y,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [LANES-1:0]   fail_lane,
    output logic [NUM_VEC-1:0] fail_vec
);

    state_e             state_q;
    logic [1:0]         v_q;
    logic [NUM_VEC-1:0] tt_q;
    logic               a_q;
    logic               b_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic [LANES-1:0]   fail_lane_q;
    logic [NUM_VEC-1:0] fail_vec_q;

    logic [LANES-1:0]   mism;
    logic [LANES-1:0]   fail_lane_d;
    logic [1:0]         v_d;
    logic               any_mism;
    logic               stop_early;
    logic               settle_expire;

    gate_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q != ST_SETTLE),
        .en    (state_q == ST_SETTLE),
        .expire(settle_expire)
    );

    assign mism        = y ^ {LANES{tt_q[v_q]}};
    assign any_mism    = |mism;
    assign fail_lane_d = fail_lane_q | mism;
    assign v_d         = v_q + 2'd1;

`ifdef GATE_CHECKER_ABORT_EN
    assign stop_early = any_mism;
`else
    assign stop_early = 1'b0;
`endif

    assign a         = {LANES{a_q}};
    assign b         = {LANES{b_q}};
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_lane = fail_lane_q;
    assign fail_vec  = fail_vec_q;

    // NOTE: every register here, tt_q and v_q included, is reset so a mid-run reset leaves no stale run context.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            v_q         <= 2'd0;
            tt_q        <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_lane_q <= '0;
            fail_vec_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        tt_q        <= tt;
                        v_q         <= 2'd0;
                        a_q         <= 1'b0;
                        b_q         <= 1'b0;
                        pass_q      <= 1'b0;
                        fail_lane_q <= '0;
                        fail_vec_q  <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_expire) state_q <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    fail_lane_q <= fail_lane_d;
                    if (any_mism) fail_vec_q[v_q] <= 1'b1;
                    if (v_q != 2'd3 && !stop_early) begin
                        v_q     <= v_d;
                        a_q     <= v_d[1];
                        b_q     <= v_d[0];
                        state_q <= ST_SETTLE;
                    end else begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        pass_q  <= (fail_lane_d == '0);
                        a_q     <= 1'b0;
                        b_q     <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ic_gate_checker.sv
// Scoreboard bench for ic_gate_checker driving modelled ic_7402 (NOR) lanes.
module tb_ic_gate_checker;
    import gate_checker_pkg::*;

    typedef struct {
        logic       pass;
        logic [3:0] fl;
        logic [3:0] fv;
        int         cycles;
        int         nvec;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] tt = '0;
    logic [3:0] a, b, y, fail_lane;
    logic [3:0] fail_vec;
    logic       busy, done, pass;
    logic [3:0] force_zero = '0;

    logic       start1 = 1'b0;
    logic [3:0] a1, b1, y1, fail_lane1, fail_vec1;
    logic       busy1, done1, pass1;

    int tests = 0;
    int fails = 0;

    exp_t       sb_q[$];
    int         busy_cnt = 0;
    int         nlog = 0;
    logic [1:0] ab_log[4];
    logic [1:0] ab_last = '0;

    always #5 clk = ~clk;

    assign y  = ~(a | b) & ~force_zero;
    assign y1 = ~(a1 | b1);

    ic_gate_checker #(.LANES(4), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tt(tt), .a(a), .b(b), .y(y),
        .busy(busy), .done(done), .pass(pass), .fail_lane(fail_lane), .fail_vec(fail_vec)
    );

    ic_gate_checker #(.LANES(4), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .tt(TT_NOR), .a(a1), .b(b1), .y(y1),
        .busy(busy1), .done(done1), .pass(pass1), .fail_lane(fail_lane1), .fail_vec(fail_vec1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: logs applied vectors and busy length, scores each done pulse against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt = 0;
            nlog = 0;
        end else begin
            if (busy) begin
                if (nlog == 0 || {a[0], b[0]} != ab_last) begin
                    if (nlog < 4) ab_log[nlog] = {a[0], b[0]};
                    nlog++;
                    ab_last = {a[0], b[0]};
                end
                busy_cnt++;
            end
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("pass", pass, e.pass);
                    check("fail_lane", fail_lane, e.fl);
                    check("fail_vec", fail_vec, e.fv);
                    check("busy_cycles", busy_cnt, e.cycles);
                    check("busy_at_done", busy, 0);
                    check("num_vectors", nlog, e.nvec);
                    for (int i = 0; i < 4; i++)
                        if (i < e.nvec) check($sformatf("ab_seq%0d", i), ab_log[i], i);
                end
                busy_cnt = 0;
                nlog = 0;
                for (int i = 0; i < 4; i++) ab_log[i] = 'x;
            end
        end
    end

    task automatic push(input logic p, input logic [3:0] fl, input logic [3:0] fv,
                        input int cyc, input int nv);
        exp_t e;
        e.pass = p; e.fl = fl; e.fv = fv; e.cycles = cyc; e.nvec = nv;
        sb_q.push_back(e);
    endtask

    task automatic pulse_start(input logic [3:0] t);
        @(negedge clk);
        tt = t;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb_q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, (n < 200), 1);
        @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ab", {a, b}, 0);
        check("rst_flags", {busy, done, pass}, 0);
        check("rst_masks", {fail_lane, fail_vec}, 0);

        // Healthy NOR lanes against the NOR table.
        push(1'b1, 4'b0000, 4'b0000, 12, 4);
        pulse_start(TT_NOR);
        wait_drain("to_nor");
        check("pass_held", pass, 1);

        // Healthy NOR lanes against the AND table: vectors 0 and 3 disagree on all lanes.
`ifdef GATE_CHECKER_ABORT_EN
        push(1'b0, 4'b1111, 4'b0001, 3, 1);
`else
        push(1'b0, 4'b1111, 4'b1001, 12, 4);
`endif
        pulse_start(TT_AND);
        wait_drain("to_and");

        // Lane 2 stuck at 0 only disagrees on vector 0.
        force_zero = 4'b0100;
`ifdef GATE_CHECKER_ABORT_EN
        push(1'b0, 4'b0100, 4'b0001, 3, 1);
`else
        push(1'b0, 4'b0100, 4'b0001, 12, 4);
`endif
        pulse_start(TT_NOR);
        wait_drain("to_stuck");
        force_zero = 4'b0000;

        // A second start mid-run is dropped; only one done may appear.
        push(1'b1, 4'b0000, 4'b0000, 12, 4);
        pulse_start(TT_NOR);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain("to_restart");
        repeat (20) @(negedge clk);
        check("no_queued_run", busy, 0);

        // Start held high: two runs separated by exactly one idle cycle.
        push(1'b1, 4'b0000, 4'b0000, 12, 4);
        push(1'b1, 4'b0000, 4'b0000, 12, 4);
        @(negedge clk);
        tt = TT_NOR;
        start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        check("to_b2b_first", (n < 100), 1);
        @(negedge clk);
        check("b2b_gap_idle", busy, 0);
        @(negedge clk);
        check("b2b_restart", busy, 1);
        start = 1'b0;
        wait_drain("to_b2b");

        // Reset at cycle 7 of a run discards it.
        pulse_start(TT_NOR);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_ab", {a, b}, 0);
        check("mid_rst_flags", {busy, done, pass}, 0);
        check("mid_rst_masks", {fail_lane, fail_vec}, 0);
        check("mid_rst_state", dut.state_q, ST_IDLE);
        rst_n = 1'b1;
        push(1'b1, 4'b0000, 4'b0000, 12, 4);
        pulse_start(TT_NOR);
        wait_drain("to_after_rst");

        // SETTLE_CYCLES=1 instance: 8-cycle run.
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 100) begin
            if (busy1) n++;
            @(negedge clk);
        end
        check("sc1_busy_cycles", n, 8);
        check("sc1_pass", pass1, 1);
        check("sc1_masks", {fail_lane1, fail_vec1}, 0);

        check("queue_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
